clip_address_timer: RTL and testbench

// Sample-rate address generator and clip timer for the voice-recorder datapath.

---
 rtl/clip_address_timer.sv | 120 ++++++++++++
 tb/tb_clip_address_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/clip_address_timer.sv
// Sample-rate address generator and 2-second clip timer between the recorder
// controller and clip memory: strobes one memory access per sample period.
module clip_address_timer #(
  parameter int unsigned SAMPLE_DIV   = 12500,
  parameter int unsigned CLIP_SAMPLES = 16000,
  parameter int unsigned ADDR_W       = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              timer,
  input  logic [1:0]        memoryselect_clip_1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic              sample_strobe,
  output logic              seconds2,
  output logic              busy
);

  localparam int unsigned PRE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned IDX_W = ADDR_W - 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SAMPLE_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CLIP_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [PRE_W-1:0]   prescaler, prescaler_n;
  logic [IDX_W-1:0]   index, index_n;
  logic               block, block_n;
  logic               dir, dir_n;
  logic [ADDR_W-1:0]  mem_addr_n;
  logic               mem_we_n, mem_re_n, sample_strobe_n, seconds2_n, busy_n;

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      prescaler     <= '0;
      index         <= '0;
      block         <= 1'b0;
      dir           <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
      sample_strobe <= 1'b0;
      seconds2      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      prescaler     <= prescaler_n;
      index         <= index_n;
      block         <= block_n;
      dir           <= dir_n;
      mem_addr      <= mem_addr_n;
      mem_we        <= mem_we_n;
      mem_re        <= mem_re_n;
      sample_strobe <= sample_strobe_n;
      seconds2      <= seconds2_n;
      busy          <= busy_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n         = state;
    prescaler_n     = prescaler;
    index_n         = index;
    block_n         = block;
    dir_n           = dir;
    mem_addr_n      = mem_addr;
    mem_we_n        = 1'b0;
    mem_re_n        = 1'b0;
    sample_strobe_n = 1'b0;
    seconds2_n      = 1'b0;
    busy_n          = 1'b0;

    case (state)
      IDLE: begin
        if (timer) begin
          block_n     = memoryselect_clip_1[1];
          dir_n       = memoryselect_clip_1[0];
          prescaler_n = '0;
          index_n     = '0;
          busy_n      = 1'b1;
          state_n     = RUN;
        end
      end
      RUN: begin
        // Dropping timer aborts immediately, including a strobe due this edge
        if (!timer) begin
          state_n = IDLE;
        end else begin
          busy_n = 1'b1;
          if (prescaler == PRE_LAST) begin
            prescaler_n     = '0;
            sample_strobe_n = 1'b1;
            mem_addr_n      = {block, index};
            mem_we_n        = dir;
            mem_re_n        = ~dir;
            index_n         = index + IDX_W'(1);
            if (index == IDX_LAST) begin
              busy_n  = 1'b0;
              state_n = DONE;
            end
          end else begin
            prescaler_n = prescaler + PRE_W'(1);
          end
        end
      end
      DONE: begin
        // The final strobe is still high only on the first DONE cycle
        seconds2_n = sample_strobe;
        if (!timer) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_clip_address_timer.sv
// Directed bench for clip_address_timer with SAMPLE_DIV=4, CLIP_SAMPLES=5, ADDR_W=4.
module tb_clip_address_timer;

  logic       clock;
  logic       reset;
  logic       timer;
  logic [1:0] sel;
  logic [3:0] mem_addr;
  logic       mem_we, mem_re, sample_strobe, seconds2, busy;

  int checks = 0;
  int errors = 0;

  clip_address_timer #(
    .SAMPLE_DIV  (4),
    .CLIP_SAMPLES(5),
    .ADDR_W      (4)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .timer              (timer),
    .memoryselect_clip_1(sel),
    .mem_addr           (mem_addr),
    .mem_we             (mem_we),
    .mem_re             (mem_re),
    .sample_strobe      (sample_strobe),
    .seconds2           (seconds2),
    .busy               (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_strobe"}, 32'(sample_strobe), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_re"}, 32'(mem_re), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_quiet(tag);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_s2"}, 32'(seconds2), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Entry edge: busy rises, nothing strobed yet
  task automatic start(input string tag);
    timer = 1'b1;
    tick();
    chk({tag, "_busy_entry"}, 32'(busy), 32'd1);
    chk({tag, "_strobe_entry"}, 32'(sample_strobe), 32'd0);
  endtask

  // Three quiet cycles then a strobe on the fourth
  task automatic wait_strobe(input string tag, input logic [3:0] addr, input logic we,
                             input logic busy_exp);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet({tag, "_gap"});
    end
    tick();
    chk({tag, "_strobe"}, 32'(sample_strobe), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
    chk({tag, "_we"}, 32'(mem_we), 32'(we));
    chk({tag, "_re"}, 32'(mem_re), 32'(!we));
    chk({tag, "_busy"}, 32'(busy), 32'(busy_exp));
    chk({tag, "_s2"}, 32'(seconds2), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    timer = 1'b0;
    sel   = 2'b00;
    tick();
    tick();
    chk_all_zero("por");
    reset = 1'b0;

    // 1: async reset mid-cycle while running
    timer = 1'b1;
    tick();
    tick();
    chk("t1_busy_pre", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1 chk_all_zero("t1_async");
    #1 reset = 1'b0;
    timer = 1'b0;
    tick();
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // 2: write clip in block 0
    sel = 2'b01;
    start("t2");
    for (int k = 0; k < 5; k++) wait_strobe("t2", 4'(k), 1'b1, logic'(k < 4));
    tick();
    chk("t2_s2", 32'(seconds2), 32'd1);
    chk("t2_busy_done", 32'(busy), 32'd0);
    chk_quiet("t2_done");
    chk("t2_addr_hold", 32'(mem_addr), 32'd4);
    tick();
    chk("t2_s2_off", 32'(seconds2), 32'd0);
    timer = 1'b0;
    tick();

    // 3: read clip in block 1, no retrigger while timer held
    sel = 2'b10;
    start("t3");
    for (int k = 0; k < 5; k++) wait_strobe("t3", 4'(8 + k), 1'b0, logic'(k < 4));
    tick();
    chk("t3_s2", 32'(seconds2), 32'd1);
    tick();
    chk("t3_s2_off", 32'(seconds2), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_quiet("t3_hold");
      chk("t3_hold_busy", 32'(busy), 32'd0);
      chk("t3_hold_s2", 32'(seconds2), 32'd0);
    end
    timer = 1'b0;
    tick();
    start("t3_re");
    wait_strobe("t3_re", 4'd8, 1'b0, 1'b1);
    timer = 1'b0;
    tick();
    chk("t3_abort_busy", 32'(busy), 32'd0);

    // 4: abort after second strobe, then restart at 0
    sel = 2'b01;
    start("t4");
    wait_strobe("t4", 4'd0, 1'b1, 1'b1);
    wait_strobe("t4", 4'd1, 1'b1, 1'b1);
    timer = 1'b0;
    tick();
    chk("t4_abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_quiet("t4_idle");
      chk("t4_idle_s2", 32'(seconds2), 32'd0);
    end
    start("t4_re");
    wait_strobe("t4_re", 4'd0, 1'b1, 1'b1);
    timer = 1'b0;
    tick();

    // Abort on the same edge as a due strobe suppresses it
    start("ab1");
    for (int i = 0; i < 3; i++) tick();
    timer = 1'b0;
    tick();
    chk_quiet("ab1_supp");
    chk("ab1_busy", 32'(busy), 32'd0);

    // Abort on the last strobe edge: no strobe, no seconds2
    start("ab2");
    for (int k = 0; k < 4; k++) wait_strobe("ab2", 4'(k), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    timer = 1'b0;
    tick();
    chk_quiet("ab2_supp");
    tick();
    chk("ab2_s2", 32'(seconds2), 32'd0);
    chk("ab2_busy", 32'(busy), 32'd0);

    // 5: select change mid-run is ignored
    sel = 2'b01;
    start("t5");
    wait_strobe("t5", 4'd0, 1'b1, 1'b1);
    sel = 2'b10;
    for (int k = 1; k < 5; k++) wait_strobe("t5", 4'(k), 1'b1, logic'(k < 4));
    tick();
    chk("t5_s2", 32'(seconds2), 32'd1);
    timer = 1'b0;
    tick();

    // 6: reset at index 3, then restart from index 0
    sel = 2'b01;
    start("t6");
    for (int k = 0; k < 3; k++) wait_strobe("t6", 4'(k), 1'b1, 1'b1);
    tick();
    #2 reset = 1'b1;
    #1 chk_all_zero("t6_async");
    #1 reset = 1'b0;
    tick();
    chk("t6_busy_entry", 32'(busy), 32'd1);
    wait_strobe("t6_re", 4'd0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
